uart_word_sequencer: RTL and testbench



---
 rtl/uart_seq_pkg.sv | 38 +++
 rtl/uart_word_sequencer.sv | 171 +++++++++++++++++
 tb/tb_uart_word_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_seq_pkg
//  Description : Shared types and helpers for the FIFO-word-to-UART-byte
//                sequencer: FSM state encoding, default frame marker and the
//                byte-select function used to slice a 32-bit word into bytes.
//  Contents    : seq_state_e       - sequencer FSM states
//                DEFAULT_SYNC_BYTE - default frame marker byte
//                sel_byte()        - pick byte idx of a word, MSB- or LSB-first
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } seq_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Byte idx of a word carrying bpw bytes. MSB-first counts down from the
  // top populated byte, so a 2-byte word sends [15:8] then [7:0].
  function automatic logic [7:0] sel_byte(
    input logic [31:0] word,
    input logic [1:0]  idx,
    input logic [2:0]  bpw,
    input logic        msb_first
  );
    logic [1:0] pos;
    pos = msb_first ? 2'(bpw - 3'd1 - {1'b0, idx}) : idx;
    return word[{pos, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_sequencer
//  Description : Pops 32-bit words from a sample FIFO and feeds them, one byte
//                at a time, to a byte-wide UART transmitter. Each word may be
//                prefixed by a sync byte. Every byte is handshaked with the
//                transmitter: a one-cycle write strobe, then busy rising and
//                falling. A missing busy response is flagged (sticky) and the
//                byte is treated as sent so the sequence never stalls.
//  Ports       : clk_50m    in   system clock
//                reset      in   synchronous active-high reset
//                enable     in   allows new words to start (level)
//                fifo_empty in   FIFO read-side empty flag
//                fifo_q     in   FIFO read data [31:0]
//                fifo_rdreq out  one-cycle pop request
//                tx_busy    in   transmitter busy
//                tx_data    out  byte to transmitter [7:0]
//                tx_wr_en   out  one-cycle write strobe
//                seq_busy   out  high whenever the FSM is not idle
//                words_sent out  completed-word counter [15:0], wraps
//                ack_err    out  sticky busy-acknowledge timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_sequencer
  import uart_seq_pkg::*;
#(
  parameter int         BYTES_PER_WORD = 4,
  parameter bit         MSB_FIRST      = 1'b1,
  parameter bit         SYNC_EN        = 1'b1,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         RD_LATENCY     = 1,
  parameter int         ACK_TIMEOUT    = 16
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_q,
  output logic        fifo_rdreq,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  output logic        seq_busy,
  output logic [15:0] words_sent,
  output logic        ack_err
);

  localparam int               TMO_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]       c_bpw      = 3'(BYTES_PER_WORD);
  localparam logic [1:0]       c_last_idx = 2'(BYTES_PER_WORD - 1);
  localparam logic [1:0]       c_rd_lat   = 2'(RD_LATENCY);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] c_tmo_one  = TMO_W'(1);

  seq_state_e       state_q;
  logic [1:0]       lat_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [1:0]       byte_idx_q;
  logic             sync_q;      // current byte is the frame marker
  logic [31:0]      word_q;

  logic             fifo_rdreq_q;
  logic [7:0]       tx_data_q;
  logic             tx_wr_en_q;
  logic             seq_busy_q;
  logic [15:0]      words_sent_q;
  logic             ack_err_q;

  logic [7:0]       tx_byte_d;
  logic [15:0]      words_sent_d;

  assign tx_byte_d    = sync_q ? SYNC_BYTE
                               : sel_byte(word_q, byte_idx_q, c_bpw, MSB_FIRST);
  assign words_sent_d = words_sent_q + 16'd1;

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      byte_idx_q   <= '0;
      sync_q       <= 1'b0;
      word_q       <= '0;
      fifo_rdreq_q <= 1'b0;
      tx_data_q    <= '0;
      tx_wr_en_q   <= 1'b0;
      seq_busy_q   <= 1'b0;
      words_sent_q <= '0;
      ack_err_q    <= 1'b0;
    end else begin
      // Both strobes are single-cycle; only the states below raise them.
      fifo_rdreq_q <= 1'b0;
      tx_wr_en_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // tx_busy is checked so a word never starts on a transmitter that
          // is still draining something else.
          if (enable && !fifo_empty && !tx_busy) begin
            fifo_rdreq_q <= 1'b1;
            lat_cnt_q    <= '0;
            seq_busy_q   <= 1'b1;
            state_q      <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // The first RD_WAIT cycle carries the pop request itself, so the
          // count reaching RD_LATENCY means fifo_q has been valid for a cycle.
          if (lat_cnt_q == c_rd_lat) begin
            word_q     <= fifo_q;
            sync_q     <= SYNC_EN;
            byte_idx_q <= '0;
            state_q    <= SEND;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end

        SEND: begin
          tx_data_q  <= tx_byte_d;
          tx_wr_en_q <= 1'b1;
          tmo_cnt_q  <= '0;
          state_q    <= WAIT_HI;
        end

        WAIT_HI: begin
          if (tx_busy) begin
            state_q <= WAIT_LO;
          end else if (tmo_cnt_q == c_tmo_last) begin
            // No acknowledge: flag it and move on as if the byte went out.
            ack_err_q <= 1'b1;
            state_q   <= WAIT_LO;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + c_tmo_one;
          end
        end

        WAIT_LO: begin
          if (!tx_busy) begin
            if (sync_q) begin
              sync_q  <= 1'b0;
              state_q <= SEND;
            end else if (byte_idx_q < c_last_idx) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= SEND;
            end else begin
              words_sent_q <= words_sent_d;
              seq_busy_q   <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end

        default: begin
          seq_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rdreq = fifo_rdreq_q;
  assign tx_data    = tx_data_q;
  assign tx_wr_en   = tx_wr_en_q;
  assign seq_busy   = seq_busy_q;
  assign words_sent = words_sent_q;
  assign ack_err    = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_sequencer
//  Description : Self-checking bench for uart_word_sequencer. Instance A uses
//                the default configuration (MSB-first, sync byte); instance B
//                is LSB-first without sync byte. Each has a FIFO model and a
//                transmitter model that holds busy for 3 cycles per strobe.
//                Expected bytes go into a scoreboard queue as words are pushed
//                and are compared against bytes captured at each tx_wr_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  // ---------------- instance A signals ----------------
  logic        enable_a     = 1'b0;
  logic        fifo_empty_a = 1'b1;
  logic [31:0] fifo_q_a     = '0;
  logic        fifo_rdreq_a;
  logic        tx_busy_a    = 1'b0;
  logic [7:0]  tx_data_a;
  logic        tx_wr_en_a;
  logic        seq_busy_a;
  logic [15:0] words_sent_a;
  logic        ack_err_a;

  // ---------------- instance B signals ----------------
  logic        enable_b     = 1'b0;
  logic        fifo_empty_b = 1'b1;
  logic [31:0] fifo_q_b     = '0;
  logic        fifo_rdreq_b;
  logic        tx_busy_b    = 1'b0;
  logic [7:0]  tx_data_b;
  logic        tx_wr_en_b;
  logic        seq_busy_b;
  logic [15:0] words_sent_b;
  logic        ack_err_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo_mem_a[$];
  logic [31:0] fifo_mem_b[$];
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  logic [7:0]  obs_a[$];
  logic [7:0]  obs_b[$];

  int rd_cnt_a = 0;
  int wr_cnt_a = 0;
  int rd_cnt_b = 0;

  logic       no_ack_a      = 1'b0;
  logic [1:0] bcnt_a        = '0;
  logic [1:0] bcnt_b        = '0;
  logic [7:0] held_a        = '0;
  logic       rd_empty_err_a = 1'b0;
  logic       rd_empty_err_b = 1'b0;
  logic       wr_busy_err_a = 1'b0;
  logic       unstable_a    = 1'b0;

  uart_word_sequencer dut_a (
    .clk_50m    (clk),
    .reset      (reset),
    .enable     (enable_a),
    .fifo_empty (fifo_empty_a),
    .fifo_q     (fifo_q_a),
    .fifo_rdreq (fifo_rdreq_a),
    .tx_busy    (tx_busy_a),
    .tx_data    (tx_data_a),
    .tx_wr_en   (tx_wr_en_a),
    .seq_busy   (seq_busy_a),
    .words_sent (words_sent_a),
    .ack_err    (ack_err_a)
  );

  uart_word_sequencer #(
    .MSB_FIRST (1'b0),
    .SYNC_EN   (1'b0)
  ) dut_b (
    .clk_50m    (clk),
    .reset      (reset),
    .enable     (enable_b),
    .fifo_empty (fifo_empty_b),
    .fifo_q     (fifo_q_b),
    .fifo_rdreq (fifo_rdreq_b),
    .tx_busy    (tx_busy_b),
    .tx_data    (tx_data_b),
    .tx_wr_en   (tx_wr_en_b),
    .seq_busy   (seq_busy_b),
    .words_sent (words_sent_b),
    .ack_err    (ack_err_b)
  );

  // FIFO models: one-cycle read latency, registered empty flag.
  always @(posedge clk) begin
    if (fifo_rdreq_a) begin
      if (fifo_mem_a.size() == 0) rd_empty_err_a <= 1'b1;
      else fifo_q_a <= fifo_mem_a.pop_front();
    end
    fifo_empty_a <= (fifo_mem_a.size() == 0);
  end

  always @(posedge clk) begin
    if (fifo_rdreq_b) begin
      if (fifo_mem_b.size() == 0) rd_empty_err_b <= 1'b1;
      else fifo_q_b <= fifo_mem_b.pop_front();
    end
    fifo_empty_b <= (fifo_mem_b.size() == 0);
  end

  // Transmitter models: busy rises the edge after the strobe, lasts 3 cycles.
  always @(posedge clk) begin
    if (reset) begin
      tx_busy_a <= 1'b0;
      bcnt_a    <= '0;
    end else if (tx_wr_en_a && !no_ack_a) begin
      tx_busy_a <= 1'b1;
      bcnt_a    <= 2'd3;
      held_a    <= tx_data_a;
    end else if (bcnt_a == 2'd1) begin
      tx_busy_a <= 1'b0;
      bcnt_a    <= '0;
    end else if (bcnt_a != 2'd0) begin
      bcnt_a <= bcnt_a - 2'd1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      tx_busy_b <= 1'b0;
      bcnt_b    <= '0;
    end else if (tx_wr_en_b) begin
      tx_busy_b <= 1'b1;
      bcnt_b    <= 2'd3;
    end else if (bcnt_b == 2'd1) begin
      tx_busy_b <= 1'b0;
      bcnt_b    <= '0;
    end else if (bcnt_b != 2'd0) begin
      bcnt_b <= bcnt_b - 2'd1;
    end
  end

  // Output capture on the falling edge.
  always @(negedge clk) begin
    if (tx_wr_en_a) begin
      obs_a.push_back(tx_data_a);
      wr_cnt_a = wr_cnt_a + 1;
      if (tx_busy_a) wr_busy_err_a = 1'b1;
    end
    if (fifo_rdreq_a) rd_cnt_a = rd_cnt_a + 1;
    if (tx_busy_a && tx_data_a !== held_a) unstable_a = 1'b1;
    if (tx_wr_en_b) obs_b.push_back(tx_data_b);
    if (fifo_rdreq_b) rd_cnt_b = rd_cnt_b + 1;
  end

  // Stimulus helper: queue a word into FIFO A and its expected frame.
  task automatic push_word_a(input logic [31:0] w);
    fifo_mem_a.push_back(w);
    exp_a.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_a.push_back(w[31 - 8*i -: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (fifo_rdreq_a !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq: got %b want 0", fifo_rdreq_a); end
    n_checks++; if (tx_wr_en_a !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", tx_wr_en_a); end
    n_checks++; if (tx_data_a !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data_a); end
    n_checks++; if (seq_busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_seq_busy: got %b want 0", seq_busy_a); end
    n_checks++; if (words_sent_a !== 16'h0000) begin n_fail++; $display("FAIL reset_words: got %h want 0000", words_sent_a); end
    n_checks++; if (ack_err_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0", ack_err_a); end
    n_checks++; if (words_sent_b !== 16'h0000) begin n_fail++; $display("FAIL reset_words_b: got %h want 0000", words_sent_b); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int rd0;
    logic [7:0] g, e;
    rd0 = rd_cnt_a;
    fifo_mem_a.push_back(32'h12345678);
    exp_a.push_back(8'hA5); exp_a.push_back(8'h12); exp_a.push_back(8'h34);
    exp_a.push_back(8'h56); exp_a.push_back(8'h78);
    enable_a = 1'b1;
    for (int c = 0; c < 400 && words_sent_a !== 16'd1; c++) @(negedge clk);
    n_checks++; if (words_sent_a !== 16'd1) begin n_fail++; $display("FAIL basic_words: got %0d want 1", words_sent_a); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (obs_a.size() == 0) begin n_fail++; $display("FAIL basic_byte: got none want %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL basic_byte: got %h want %h", g, e); end
      end
    end
    @(negedge clk);
    n_checks++; if (rd_cnt_a - rd0 != 1) begin n_fail++; $display("FAIL basic_pops: got %0d want 1", rd_cnt_a - rd0); end
    n_checks++; if (seq_busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_seq_busy: got %b want 0", seq_busy_a); end
  endtask

  task automatic test_lsb_nosync();
    logic [7:0] g, e;
    fifo_mem_b.push_back(32'hDEADBEEF);
    exp_b.push_back(8'hEF); exp_b.push_back(8'hBE);
    exp_b.push_back(8'hAD); exp_b.push_back(8'hDE);
    enable_b = 1'b1;
    for (int c = 0; c < 400 && words_sent_b !== 16'd1; c++) @(negedge clk);
    n_checks++; if (words_sent_b !== 16'd1) begin n_fail++; $display("FAIL lsb_words: got %0d want 1", words_sent_b); end
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front();
      n_checks++;
      if (obs_b.size() == 0) begin n_fail++; $display("FAIL lsb_byte: got none want %h", e); end
      else begin
        g = obs_b.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL lsb_byte: got %h want %h", g, e); end
      end
    end
    n_checks++; if (obs_b.size() != 0) begin n_fail++; $display("FAIL lsb_extra: got %0d extra bytes want 0", obs_b.size()); end
    n_checks++; if (rd_cnt_b != 1) begin n_fail++; $display("FAIL lsb_pops: got %0d want 1", rd_cnt_b); end
    n_checks++; if (rd_empty_err_b !== 1'b0) begin n_fail++; $display("FAIL lsb_pop_empty: got %b want 0", rd_empty_err_b); end
  endtask

  task automatic test_back_to_back();
    int rd0, wr0;
    logic [7:0] g, e;
    rd0 = rd_cnt_a;
    wr0 = wr_cnt_a;
    repeat (100) @(negedge clk);
    n_checks++; if (rd_cnt_a != rd0) begin n_fail++; $display("FAIL empty_rdreq: got %0d pops want 0", rd_cnt_a - rd0); end
    n_checks++; if (wr_cnt_a != wr0) begin n_fail++; $display("FAIL empty_wr_en: got %0d strobes want 0", wr_cnt_a - wr0); end
    push_word_a(32'hCAFEF00D);
    push_word_a(32'h01020304);
    for (int c = 0; c < 800 && words_sent_a !== 16'd3; c++) @(negedge clk);
    n_checks++; if (words_sent_a !== 16'd3) begin n_fail++; $display("FAIL b2b_words: got %0d want 3", words_sent_a); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (obs_a.size() == 0) begin n_fail++; $display("FAIL b2b_byte: got none want %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL b2b_byte: got %h want %h", g, e); end
      end
    end
    n_checks++; if (rd_cnt_a - rd0 != 2) begin n_fail++; $display("FAIL b2b_pops: got %0d want 2", rd_cnt_a - rd0); end
    n_checks++; if (wr_busy_err_a !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe_while_busy: got %b want 0", wr_busy_err_a); end
    n_checks++; if (unstable_a !== 1'b0) begin n_fail++; $display("FAIL b2b_data_stable: got %b want 0", unstable_a); end
    n_checks++; if (rd_empty_err_a !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_empty: got %b want 0", rd_empty_err_a); end
  endtask

  task automatic test_ack_timeout();
    logic [7:0] g, e;
    no_ack_a = 1'b1;
    push_word_a(32'h11223344);
    for (int c = 0; c < 100 && obs_a.size() == 0; c++) @(negedge clk);
    repeat (8) @(negedge clk);
    n_checks++; if (ack_err_a !== 1'b0) begin n_fail++; $display("FAIL ack_early: got %b want 0", ack_err_a); end
    for (int c = 0; c < 1000 && words_sent_a !== 16'd4; c++) @(negedge clk);
    n_checks++; if (words_sent_a !== 16'd4) begin n_fail++; $display("FAIL ack_words: got %0d want 4", words_sent_a); end
    n_checks++; if (ack_err_a !== 1'b1) begin n_fail++; $display("FAIL ack_err_set: got %b want 1", ack_err_a); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (obs_a.size() == 0) begin n_fail++; $display("FAIL ack_byte: got none want %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL ack_byte: got %h want %h", g, e); end
      end
    end
    no_ack_a = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ack_err_a !== 1'b1) begin n_fail++; $display("FAIL ack_sticky: got %b want 1", ack_err_a); end
  endtask

  task automatic test_reset_mid();
    int rd0;
    logic [7:0] g, e;
    push_word_a(32'hA1B2C3D4);
    // Wait for the strobe of byte index 2 (fourth byte incl. sync).
    for (int c = 0; c < 400 && obs_a.size() < 4; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++; if (seq_busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", seq_busy_a); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (seq_busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_seq_busy: got %b want 0", seq_busy_a); end
    n_checks++; if (tx_data_a !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %h want 00", tx_data_a); end
    n_checks++; if (tx_wr_en_a !== 1'b0 || fifo_rdreq_a !== 1'b0) begin n_fail++; $display("FAIL mid_strobes: got wr=%b rd=%b want 0 0", tx_wr_en_a, fifo_rdreq_a); end
    n_checks++; if (words_sent_a !== 16'd0 || ack_err_a !== 1'b0) begin n_fail++; $display("FAIL mid_counters: got words=%0d ack=%b want 0 0", words_sent_a, ack_err_a); end
    reset = 1'b0;
    exp_a.delete();
    obs_a.delete();
    rd0 = rd_cnt_a;
    push_word_a(32'h0F1E2D3C);
    for (int c = 0; c < 400 && words_sent_a !== 16'd1; c++) @(negedge clk);
    n_checks++; if (words_sent_a !== 16'd1) begin n_fail++; $display("FAIL mid_words: got %0d want 1", words_sent_a); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (obs_a.size() == 0) begin n_fail++; $display("FAIL mid_byte: got none want %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL mid_byte: got %h want %h", g, e); end
      end
    end
    n_checks++; if (rd_cnt_a - rd0 != 1) begin n_fail++; $display("FAIL mid_pops: got %0d want 1", rd_cnt_a - rd0); end
  endtask

  task automatic test_wrap();
    repeat (2) @(negedge clk);
    force dut_a.words_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.words_sent_q;
    @(negedge clk);
    n_checks++; if (words_sent_a !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", words_sent_a); end
    push_word_a(32'h89ABCDEF);
    for (int c = 0; c < 400 && words_sent_a !== 16'h0000; c++) @(negedge clk);
    n_checks++; if (words_sent_a !== 16'h0000) begin n_fail++; $display("FAIL wrap_words: got %h want 0000", words_sent_a); end
    n_checks++; if (obs_a.size() != 5) begin n_fail++; $display("FAIL wrap_bytes: got %0d bytes want 5", obs_a.size()); end
    exp_a.delete();
    obs_a.delete();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_lsb_nosync();
    test_back_to_back();
    test_ack_timeout();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
